// File: rtl/jtag_scan_master.sv
// rtl/jtag_scan_master.sv - JTAG scan initiator: runs one TAP reset/IR/DR/idle command per handshake
// Tracks the target TAP state locally and walks it with generated tms/tdi while sampling tdo.
module jtag_scan_master #(
  parameter int TCK_HALF = 2,
  parameter int DATA_W   = 32,
  parameter int LEN_W    = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo,
  output logic [3:0]        tap_state,
  output logic              busy
);
  localparam int CNT_W = LEN_W + 3;
  localparam int PH_W  = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [1:0] OP_RST = 2'd0, OP_IR = 2'd1, OP_DR = 2'd2, OP_IDLE = 2'd3;
  localparam logic [3:0] TLR = 4'h0, RTI = 4'h1, SEL_DR = 4'h2, CAP_DR = 4'h3,
                         SH_DR = 4'h4, EX1_DR = 4'h5, PAU_DR = 4'h6, EX2_DR = 4'h7,
                         UPD_DR = 4'h8, SEL_IR = 4'h9, CAP_IR = 4'hA, SH_IR = 4'hB,
                         EX1_IR = 4'hC, PAU_IR = 4'hD, EX2_IR = 4'hE, UPD_IR = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_t;
  state_t state_q, state_d;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
    case (s)
      TLR:     return m ? TLR    : RTI;
      RTI:     return m ? SEL_DR : RTI;
      SEL_DR:  return m ? SEL_IR : CAP_DR;
      CAP_DR:  return m ? EX1_DR : SH_DR;
      SH_DR:   return m ? EX1_DR : SH_DR;
      EX1_DR:  return m ? UPD_DR : PAU_DR;
      PAU_DR:  return m ? EX2_DR : PAU_DR;
      EX2_DR:  return m ? UPD_DR : SH_DR;
      UPD_DR:  return m ? SEL_DR : RTI;
      SEL_IR:  return m ? TLR    : CAP_IR;
      CAP_IR:  return m ? EX1_IR : SH_IR;
      SH_IR:   return m ? EX1_IR : SH_IR;
      EX1_IR:  return m ? UPD_IR : PAU_IR;
      PAU_IR:  return m ? EX2_IR : PAU_IR;
      EX2_IR:  return m ? UPD_IR : SH_IR;
      default: return m ? SEL_DR : RTI;
    endcase
  endfunction

  // Index (after any preamble TCK) of the first shift TCK.
  function automatic logic [CNT_W-1:0] shift_start(input logic [1:0] op);
    return (op == OP_IR) ? CNT_W'(4) : CNT_W'(3);
  endfunction

  function automatic logic is_shift(input logic [1:0] op, input logic [CNT_W-1:0] len,
                                    input logic pre, input logic [CNT_W-1:0] idx);
    logic [CNT_W-1:0] j, ss;
    j  = idx - CNT_W'(pre);
    ss = shift_start(op);
    return (op == OP_IR || op == OP_DR) && !(pre && idx == '0) && (j >= ss) && (j < ss + len);
  endfunction

  function automatic logic [IDX_W-1:0] shift_idx(input logic [1:0] op, input logic pre,
                                                 input logic [CNT_W-1:0] idx);
    return IDX_W'(idx - CNT_W'(pre) - shift_start(op));
  endfunction

  function automatic logic tms_at(input logic [1:0] op, input logic [CNT_W-1:0] len,
                                  input logic pre, input logic [CNT_W-1:0] idx);
    logic [CNT_W-1:0] j, ss;
    j  = idx - CNT_W'(pre);
    ss = shift_start(op);
    if (pre && idx == '0) return 1'b0;
    case (op)
      OP_RST:  return j < CNT_W'(5);
      OP_IDLE: return 1'b0;
      default: begin
        if (j < ss) return (op == OP_IR) ? (j < CNT_W'(2)) : (j == '0);
        // Last shift bit leaves Shift, next TCK enters Update, then back to RTI.
        return (j >= ss + len - CNT_W'(1)) && (j <= ss + len);
      end
    endcase
  endfunction

  logic              tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [CNT_W-1:0]  k_q, k_d, n_q, n_d, len_q, len_d, k_nx, len_in, n_in;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d, rdata_q, rdata_d;
  logic              pre_q, pre_d, fin_q, fin_d, err_q, err_d;
  logic [3:0]        tap_q, tap_d;
  logic              accept, pre_in, err_in;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid) state_d = S_RUN;
      S_RUN:   if (fin_q) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    busy      = (state_q != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tck_q <= 1'b0; tms_q <= 1'b1; tdi_q <= 1'b0; ph_q <= '0; k_q <= '0; n_q <= '0;
      len_q <= '0; op_q <= OP_RST; data_q <= '0; rdata_q <= '0; pre_q <= 1'b0;
      fin_q <= 1'b0; err_q <= 1'b0; tap_q <= TLR;
    end else begin
      tck_q <= tck_d; tms_q <= tms_d; tdi_q <= tdi_d; ph_q <= ph_d; k_q <= k_d; n_q <= n_d;
      len_q <= len_d; op_q <= op_d; data_q <= data_d; rdata_q <= rdata_d; pre_q <= pre_d;
      fin_q <= fin_d; err_q <= err_d; tap_q <= tap_d;
    end
  end

  always_comb begin
    accept = (state_q == S_IDLE) && cmd_valid;
    len_in = CNT_W'(cmd_len);
    pre_in = (tap_q == TLR) && (cmd_op != OP_RST);
    err_in = (cmd_op != OP_RST) && ((cmd_len == '0) || (len_in > CNT_W'(DATA_W)));
    case (cmd_op)
      OP_RST:  n_in = CNT_W'(6);
      OP_IR:   n_in = len_in + CNT_W'(6) + CNT_W'(pre_in);
      OP_DR:   n_in = len_in + CNT_W'(5) + CNT_W'(pre_in);
      default: n_in = len_in + CNT_W'(pre_in);
    endcase
    k_nx = k_q + CNT_W'(1);

    tck_d = tck_q; tms_d = tms_q; tdi_d = tdi_q; ph_d = ph_q; k_d = k_q; n_d = n_q;
    len_d = len_q; op_d = op_q; data_d = data_q; rdata_d = rdata_q; pre_d = pre_q;
    fin_d = fin_q; err_d = err_q; tap_d = tap_q;

    if (accept) begin
      op_d = cmd_op; len_d = len_in; data_d = cmd_data; pre_d = pre_in; n_d = n_in;
      err_d = err_in; fin_d = err_in; k_d = '0; ph_d = '0; tck_d = 1'b0; tdi_d = 1'b0;
      rdata_d = '0;
      if (!err_in) tms_d = tms_at(cmd_op, len_in, pre_in, '0);
    end else if (state_q == S_RUN && !fin_q) begin
      if (ph_q == PH_W'(TCK_HALF - 1)) begin
        ph_d = '0;
        if (!tck_q) begin
          tck_d = 1'b1;
          tap_d = tap_next(tap_q, tms_q);
          if (is_shift(op_q, len_q, pre_q, k_q)) rdata_d[shift_idx(op_q, pre_q, k_q)] = tdo;
        end else begin
          tck_d = 1'b0;
          if (k_q == n_q - CNT_W'(1)) begin
            fin_d = 1'b1; tms_d = 1'b0; tdi_d = 1'b0;
          end else begin
            k_d   = k_nx;
            tms_d = tms_at(op_q, len_q, pre_q, k_nx);
            tdi_d = is_shift(op_q, len_q, pre_q, k_nx) ? data_q[shift_idx(op_q, pre_q, k_nx)] : 1'b0;
          end
        end
      end else begin
        ph_d = ph_q + PH_W'(1);
      end
    end
  end

  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign tap_state = tap_q;
  assign rsp_data  = rdata_q;
  assign rsp_err   = err_q;
endmodule

// File: tb/tb_jtag_scan_master.sv
// tb/tb_jtag_scan_master.sv - directed bench for jtag_scan_master with a small target TAP model
module tb_jtag_scan_master;
  logic        clk = 1'b0;
  logic        rst, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, busy;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_data, rsp_data;
  logic        tck, tms, tdi;
  logic        tdo = 1'b0;
  logic [3:0]  tap_state;

  jtag_scan_master #(.TCK_HALF(2), .DATA_W(32), .LEN_W(6)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo),
    .tap_state(tap_state), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0, acc_cyc = 0, n_tck = 0, trst_req = 0, trst_seen = 0;
  logic        tms_log [0:1023];
  logic        tdi_log [0:1023];
  logic [3:0]  ms = 4'h0;
  logic [3:0]  ir_sr, ir_reg;
  logic [31:0] dr_sr, dr_reg, dr_cap;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] tap_nx(input logic [3:0] s, input logic m);
    case (s)
      4'h0: tap_nx = m ? 4'h0 : 4'h1;  4'h1: tap_nx = m ? 4'h2 : 4'h1;
      4'h2: tap_nx = m ? 4'h9 : 4'h3;  4'h3: tap_nx = m ? 4'h5 : 4'h4;
      4'h4: tap_nx = m ? 4'h5 : 4'h4;  4'h5: tap_nx = m ? 4'h8 : 4'h6;
      4'h6: tap_nx = m ? 4'h7 : 4'h6;  4'h7: tap_nx = m ? 4'h8 : 4'h4;
      4'h8: tap_nx = m ? 4'h2 : 4'h1;  4'h9: tap_nx = m ? 4'h0 : 4'hA;
      4'hA: tap_nx = m ? 4'hC : 4'hB;  4'hB: tap_nx = m ? 4'hC : 4'hB;
      4'hC: tap_nx = m ? 4'hF : 4'hD;  4'hD: tap_nx = m ? 4'hE : 4'hD;
      4'hE: tap_nx = m ? 4'hF : 4'hB;  default: tap_nx = m ? 4'h2 : 4'h1;
    endcase
  endfunction

  // Target side: IR captures 0x1, DR captures dr_cap, tdo changes on falling tck.
  always @(posedge tck) begin
    if (trst_req != trst_seen) begin ms = 4'h0; trst_seen = trst_req; end
    if (n_tck < 1024) begin tms_log[n_tck] = tms; tdi_log[n_tck] = tdi; end
    n_tck++;
    case (ms)
      4'h3: dr_sr = dr_cap;
      4'h4: dr_sr = {tdi, dr_sr[31:1]};
      4'h8: dr_reg = dr_sr;
      4'hA: ir_sr = 4'h1;
      4'hB: ir_sr = {tdi, ir_sr[3:1]};
      4'hF: ir_reg = ir_sr;
      default: ;
    endcase
    ms = tap_nx(ms, tms);
  end

  always @(negedge tck) tdo = (ms == 4'h4) ? dr_sr[0] : (ms == 4'hB) ? ir_sr[0] : 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack(input int base, input int n, input bit sel_tdi);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n && i < 64; i++)
      if (base + i < 1024) v[i] = sel_tdi ? tdi_log[base + i] : tms_log[base + i];
    return v;
  endfunction

  task automatic send(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
    int w;
    @(negedge clk);
    cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 200) begin @(negedge clk); w++; end
    if (!cmd_ready) chk("accept_timeout", 64'(cmd_ready), 64'(1));
    @(posedge clk); #1;
    acc_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    int w;
    w = 0;
    while (!rsp_valid && w < 3000) begin @(negedge clk); w++; end
    if (!rsp_valid) chk("rsp_timeout", 64'(rsp_valid), 64'(1));
    lat = cyc - acc_cyc;
  endtask

  task automatic take_rsp();
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  int base, lat, w, hc;
  logic [31:0] d0;
  bit ok;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = 6'd0; cmd_data = 32'h0;
    rsp_ready = 1'b0; dr_cap = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_tck", 64'(tck), 0);        chk("rst_tms", 64'(tms), 1);
    chk("rst_tdi", 64'(tdi), 0);        chk("rst_cmd_ready", 64'(cmd_ready), 1);
    chk("rst_rsp_valid", 64'(rsp_valid), 0); chk("rst_rsp_data", 64'(rsp_data), 0);
    chk("rst_rsp_err", 64'(rsp_err), 0); chk("rst_busy", 64'(busy), 0);
    chk("rst_tap", 64'(tap_state), 0);
    rst = 1'b0;

    base = n_tck; send(2'd0, 6'd0, 32'h0); wait_rsp(lat);
    chk("treset_lat", 64'(lat), 25);      chk("treset_ntck", 64'(n_tck - base), 6);
    chk("treset_tms", pack(base, 6, 0), 64'h1F);
    chk("treset_tap", 64'(tap_state), 1); chk("treset_err", 64'(rsp_err), 0);
    chk("treset_model", 64'(ms), 1);
    take_rsp();

    base = n_tck; send(2'd1, 6'd4, 32'hA); wait_rsp(lat);
    chk("ir_lat", 64'(lat), 41);          chk("ir_ntck", 64'(n_tck - base), 10);
    chk("ir_tms", pack(base, 10, 0), 64'h183);
    chk("ir_tdi", pack(base + 4, 4, 1), 64'hA);
    chk("ir_rsp", 64'(rsp_data), 64'h1);  chk("ir_model_ir", 64'(ir_reg), 64'hA);
    chk("ir_err", 64'(rsp_err), 0);
    take_rsp();

    dr_cap = 32'h12345678;
    base = n_tck; send(2'd2, 6'd32, 32'hDEADBEEF); wait_rsp(lat);
    chk("dr_lat", 64'(lat), 149);         chk("dr_ntck", 64'(n_tck - base), 37);
    chk("dr_rsp", 64'(rsp_data), 64'h12345678);
    chk("dr_model_dr", 64'(dr_reg), 64'hDEADBEEF);
    chk("dr_tap", 64'(tap_state), 1);     chk("dr_model_state", 64'(ms), 1);
    take_rsp();

    base = n_tck; send(2'd2, 6'd0, 32'hFFFF_FFFF); wait_rsp(lat);
    chk("err0_lat", 64'(lat), 1);         chk("err0_err", 64'(rsp_err), 1);
    chk("err0_data", 64'(rsp_data), 0);
    take_rsp();
    chk("err0_ntck", 64'(n_tck - base), 0);

    base = n_tck; send(2'd3, 6'd33, 32'h0); wait_rsp(lat);
    chk("err33_lat", 64'(lat), 1);        chk("err33_err", 64'(rsp_err), 1);
    take_rsp();
    chk("err33_ntck", 64'(n_tck - base), 0);

    base = n_tck; send(2'd3, 6'd3, 32'h0); wait_rsp(lat);
    chk("idle_lat", 64'(lat), 13);        chk("idle_ntck", 64'(n_tck - base), 3);
    chk("idle_tms", pack(base, 3, 0), 0); chk("idle_data", 64'(rsp_data), 0);
    chk("idle_err", 64'(rsp_err), 0);     chk("idle_tap", 64'(tap_state), 1);
    take_rsp();

    dr_cap = 32'h0000_00C3;
    send(2'd2, 6'd8, 32'h5A); wait_rsp(lat);
    d0 = rsp_data;
    chk("bp_data", 64'(d0), 64'hC3);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      ok &= rsp_valid && (rsp_data == d0) && !cmd_ready && busy;
    end
    chk("bp_stable", 64'(ok), 1);
    @(negedge clk);
    rsp_ready = 1'b1; cmd_op = 2'd3; cmd_len = 6'd1; cmd_data = 32'h0; cmd_valid = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0; hc = cyc;
    @(negedge clk);
    chk("b2b_ready", 64'(cmd_ready), 1);  chk("b2b_idle_busy", 64'(busy), 0);
    @(posedge clk); #1; acc_cyc = cyc; cmd_valid = 1'b0;
    chk("b2b_accepted", 64'(busy), 1);
    wait_rsp(lat);
    chk("b2b_lat", 64'(lat), 5);
    take_rsp();
    chk("bp_model_dr", 64'(dr_reg), 64'h5A00_0000);

    base = n_tck; send(2'd2, 6'd8, 32'hFF);
    w = 0;
    while ((n_tck - base) < 5 && w < 500) begin @(negedge clk); w++; end
    chk("mid_reach_tck5", 64'(n_tck - base), 5);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_tck", 64'(tck), 0);          chk("mid_tms", 64'(tms), 1);
    chk("mid_rsp_valid", 64'(rsp_valid), 0); chk("mid_busy", 64'(busy), 0);
    chk("mid_tap", 64'(tap_state), 0);    chk("mid_cmd_ready", 64'(cmd_ready), 1);
    rst = 1'b0; trst_req++;

    base = n_tck; send(2'd3, 6'd2, 32'h0); wait_rsp(lat);
    chk("pre_lat", 64'(lat), 13);         chk("pre_ntck", 64'(n_tck - base), 3);
    chk("pre_tms", pack(base, 3, 0), 0);  chk("pre_tap", 64'(tap_state), 1);
    chk("pre_model_state", 64'(ms), 1);
    take_rsp();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
